// File: rtl/set_pkg.sv
// Shared widths, FSM encoding, job record layout and defaults for the SET job scheduler.
package set_pkg;

   localparam int CENTRAL_W = 24;
   localparam int RADIUS_W  = 12;
   localparam int MODE_W    = 2;
   localparam int TAG_W     = 4;
   localparam int CAND_W    = 8;
   localparam int JOB_W     = CENTRAL_W + RADIUS_W + MODE_W + TAG_W;

   localparam int DEF_TIMEOUT    = 96;
   localparam int DEF_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic [CENTRAL_W-1:0] central;
      logic [RADIUS_W-1:0]  radius;
      logic [MODE_W-1:0]    mode;
      logic [TAG_W-1:0]     tag;
   } job_t;

endpackage

// File: rtl/set_job_scheduler_if.sv
// Job intake, SET engine and result channels of the scheduler.
interface set_job_scheduler_if;
   import set_pkg::*;

   logic                 job_valid;
   logic                 job_ready;
   logic [CENTRAL_W-1:0] job_central;
   logic [RADIUS_W-1:0]  job_radius;
   logic [MODE_W-1:0]    job_mode;
   logic [TAG_W-1:0]     job_tag;

   logic                 set_en;
   logic [CENTRAL_W-1:0] set_central;
   logic [RADIUS_W-1:0]  set_radius;
   logic [MODE_W-1:0]    set_mode;
   logic                 set_busy;
   logic                 set_valid;
   logic [CAND_W-1:0]    set_candidate;

   logic                 res_valid;
   logic                 res_ready;
   logic [CAND_W-1:0]    res_candidate;
   logic [TAG_W-1:0]     res_tag;
   logic                 res_err;

   // Environment side: offers jobs, models the engine, consumes results.
   modport master (
      output job_valid, job_central, job_radius, job_mode, job_tag,
      output set_busy, set_valid, set_candidate, res_ready,
      input  job_ready, set_en, set_central, set_radius, set_mode,
      input  res_valid, res_candidate, res_tag, res_err
   );

   // Scheduler side.
   modport slave (
      input  job_valid, job_central, job_radius, job_mode, job_tag,
      input  set_busy, set_valid, set_candidate, res_ready,
      output job_ready, set_en, set_central, set_radius, set_mode,
      output res_valid, res_candidate, res_tag, res_err
   );

endinterface

// File: rtl/set_job_fifo.sv
// Synchronous job FIFO; head entry is read straight from the storage flops.
module set_job_fifo
   import set_pkg::*;
#(
   parameter int DEPTH = DEF_FIFO_DEPTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  job_t             push_data,
   input  logic             pop,
   output job_t             head_data,
   output logic [LVL_W-1:0] level,
   output logic             full,
   output logic             empty
);

   job_t             mem_q [DEPTH];
   job_t             mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             push_ok, pop_ok;

   assign full      = (level_q == LVL_W'(DEPTH));
   assign empty     = (level_q == '0);
   assign push_ok   = push & ~full;
   assign pop_ok    = pop & ~empty;
   assign head_data = mem_q[rd_ptr_q];
   assign level     = level_q;

   // Pointer, storage and occupancy update; push and pop together leave level unchanged.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   // FIFO state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

endmodule

// File: rtl/set_job_scheduler.sv
// Queues SET jobs and runs them one at a time on the engine, with a result hold and timeout.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | wait for a queued job, free result slot and idle engine
//   ST_ISSUE | one-cycle set_en with the popped job on set_central/radius/mode
//   ST_WAIT  | count cycles until set_valid or the timeout terminal count
//   ST_DONE  | publish result, tag and bump jobs_done
module set_job_scheduler
   import set_pkg::*;
#(
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                clk,
   input  logic                rst,
   set_job_scheduler_if.slave  bus,
   output logic [15:0]         jobs_done,
   output logic [2:0]          fifo_level
);

   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   localparam int CNT_W = $clog2(TIMEOUT);

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [CENTRAL_W-1:0] set_central_q, set_central_d;
   logic [RADIUS_W-1:0]  set_radius_q, set_radius_d;
   logic [MODE_W-1:0]    set_mode_q, set_mode_d;
   logic [TAG_W-1:0]     cur_tag_q, cur_tag_d;
   logic                 res_valid_q, res_valid_d;
   logic [CAND_W-1:0]    res_candidate_q, res_candidate_d;
   logic [TAG_W-1:0]     res_tag_q, res_tag_d;
   logic                 res_err_q, res_err_d;
   logic [15:0]          jobs_done_q, jobs_done_d;

   job_t             job_in, head;
   logic             fifo_full, fifo_empty;
   logic [LVL_W-1:0] level;
   logic             start, timeout_hit, pop, set_en;

   assign job_in = '{central: bus.job_central, radius: bus.job_radius,
                     mode: bus.job_mode, tag: bus.job_tag};

   set_job_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (bus.job_valid),
      .push_data (job_in),
      .pop       (pop),
      .head_data (head),
      .level     (level),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign start       = (state_q == ST_IDLE) && !fifo_empty && !res_valid_q && !bus.set_busy;
   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // FSM next-state logic; set_valid wins over the timeout in the same cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT:  if (bus.set_valid || timeout_hit) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: pop the head on the way into ISSUE, strobe the engine in ISSUE.
   always_comb begin
      pop    = 1'b0;
      set_en = 1'b0;
      if (start)                pop    = 1'b1;
      if (state_q == ST_ISSUE)  set_en = 1'b1;
   end

   // Datapath next values: latched job, timeout counter, result slot and job count.
   always_comb begin
      set_central_d   = set_central_q;
      set_radius_d    = set_radius_q;
      set_mode_d      = set_mode_q;
      cur_tag_d       = cur_tag_q;
      res_candidate_d = res_candidate_q;
      res_err_d       = res_err_q;
      res_tag_d       = res_tag_q;
      jobs_done_d     = jobs_done_q;
      res_valid_d     = res_valid_q & ~bus.res_ready;
      cnt_d           = '0;

      if (start) begin
         set_central_d = head.central;
         set_radius_d  = head.radius;
         set_mode_d    = head.mode;
         cur_tag_d     = head.tag;
      end

      if (state_q == ST_WAIT) begin
         if (bus.set_valid) begin
            res_candidate_d = bus.set_candidate;
            res_err_d       = 1'b0;
         end else if (timeout_hit) begin
            res_candidate_d = '0;
            res_err_d       = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      if (state_q == ST_DONE) begin
         res_valid_d = 1'b1;
         res_tag_d   = cur_tag_q;
         jobs_done_d = jobs_done_q + 16'd1;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q           <= '0;
         set_central_q   <= '0;
         set_radius_q    <= '0;
         set_mode_q      <= '0;
         cur_tag_q       <= '0;
         res_valid_q     <= 1'b0;
         res_candidate_q <= '0;
         res_tag_q       <= '0;
         res_err_q       <= 1'b0;
         jobs_done_q     <= '0;
      end else begin
         cnt_q           <= cnt_d;
         set_central_q   <= set_central_d;
         set_radius_q    <= set_radius_d;
         set_mode_q      <= set_mode_d;
         cur_tag_q       <= cur_tag_d;
         res_valid_q     <= res_valid_d;
         res_candidate_q <= res_candidate_d;
         res_tag_q       <= res_tag_d;
         res_err_q       <= res_err_d;
         jobs_done_q     <= jobs_done_d;
      end
   end

   assign bus.job_ready     = ~fifo_full;
   assign bus.set_en        = set_en;
   assign bus.set_central   = set_central_q;
   assign bus.set_radius    = set_radius_q;
   assign bus.set_mode      = set_mode_q;
   assign bus.res_valid     = res_valid_q;
   assign bus.res_candidate = res_candidate_q;
   assign bus.res_tag       = res_tag_q;
   assign bus.res_err       = res_err_q;
   assign jobs_done         = jobs_done_q;
   assign fifo_level        = 3'(level);

endmodule

// File: tb/tb_set_job_scheduler.sv
// Bench for set_job_scheduler: engine model, result scoreboard, vector table and corner sequences.
module tb_set_job_scheduler;
   import set_pkg::*;

   localparam int TO = 96;

   logic        clk;
   logic        rst;
   logic [15:0] jobs_done;
   logic [2:0]  fifo_level;

   set_job_scheduler_if bus ();

   set_job_scheduler #(.FIFO_DEPTH(4), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .jobs_done  (jobs_done),
      .fifo_level (fifo_level)
   );

   typedef struct {
      logic [7:0] cand;
      logic [3:0] tag;
      logic       err;
      int         lat;
   } exp_t;

   typedef struct {
      logic [23:0] central;
      logic [11:0] radius;
      logic [1:0]  mode;
      logic [3:0]  tag;
      int          lat;
      bit          mute;
      logic [7:0]  cand;
      logic [7:0]  exp_cand;
      bit          exp_err;
   } vec_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   set_en_count = 0;
   int   set_en_cyc = 0;
   int   rv_rise_cyc = 0;
   int   eng_lat = 1;
   bit   eng_mute = 1'b0;
   bit   inject_sv = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic offer(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                        input logic [3:0] t);
      bus.job_central = c;
      bus.job_radius  = r;
      bus.job_mode    = m;
      bus.job_tag     = t;
      bus.job_valid   = 1'b1;
   endtask

   task automatic expect_res(input logic [7:0] cand, input logic [3:0] tag, input logic err,
                             input int lat);
      exp_t e;
      e.cand = cand;
      e.tag  = tag;
      e.err  = err;
      e.lat  = lat;
      sb.push_back(e);
   endtask

   task automatic wait_done(input int target, input int budget, input string name);
      int n = 0;
      while (!(jobs_done == 16'(target) && sb.size() == 0) && n < budget) begin
         step();
         n++;
      end
      check(name, jobs_done, 64'(target));
      check({name, "_sb_empty"}, 64'(sb.size()), 0);
   endtask

   // SET engine model: set_valid pulse eng_lat cycles after set_en, unless muted.
   initial begin
      int eng_cnt;
      bit fire;
      eng_cnt = 0;
      bus.set_valid = 1'b0;
      forever begin
         @(negedge clk);
         fire = 1'b0;
         if (rst) begin
            eng_cnt = 0;
         end else begin
            if (eng_cnt > 0) begin
               eng_cnt--;
               fire = (eng_cnt == 0);
            end
            if (bus.set_en && !eng_mute) eng_cnt = eng_lat;
         end
         bus.set_valid = fire | inject_sv;
      end
   end

   // set_en monitor.
   initial begin
      bit prev_en;
      prev_en = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.set_en) begin
            set_en_count++;
            set_en_cyc = cyc;
            check("set_en_while_busy", bus.set_busy, 0);
            check("set_en_back_to_back", prev_en, 0);
            check("set_en_with_res_valid", bus.res_valid, 0);
         end
         prev_en = bus.set_en;
      end
   end

   // Result collector: compares each consumed result against the scoreboard.
   initial begin
      bit   prev_rv;
      exp_t e;
      prev_rv = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_rv = 1'b0;
         end else begin
            if (bus.res_valid && !prev_rv) rv_rise_cyc = cyc;
            prev_rv = bus.res_valid;
            if (bus.res_valid && bus.res_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_result: got tag %0h cand %0h, required no result",
                           bus.res_tag, bus.res_candidate);
               end else begin
                  e = sb.pop_front();
                  check("res_candidate", bus.res_candidate, e.cand);
                  check("res_tag", bus.res_tag, e.tag);
                  check("res_err", bus.res_err, e.err);
                  check("latency", 64'(rv_rise_cyc - set_en_cyc), 64'(e.lat));
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[6];
      int   exp_done;
      int   base_en;
      int   max_lvl;
      int   n;
      int   rv_cnt;

      vecs[0] = '{24'h444444, 12'h333, 2'd0, 4'd5,  3,  1'b0, 8'd29,  8'd29,  1'b0};
      vecs[1] = '{24'h123456, 12'habc, 2'd2, 4'd9,  1,  1'b0, 8'hA7,  8'hA7,  1'b0};
      vecs[2] = '{24'hfedcba, 12'h0f1, 2'd3, 4'hf,  96, 1'b0, 8'h5A,  8'h5A,  1'b0};
      vecs[3] = '{24'h010203, 12'h111, 2'd1, 4'd3,  97, 1'b0, 8'h77,  8'h00,  1'b1};
      vecs[4] = '{24'h0a0b0c, 12'h222, 2'd2, 4'd7,  1,  1'b1, 8'h66,  8'h00,  1'b1};
      vecs[5] = '{24'h999999, 12'h444, 2'd1, 4'd0,  2,  1'b0, 8'hFF,  8'hFF,  1'b0};

      rst = 1'b1;
      bus.job_valid = 1'b0;
      bus.job_central = '0;
      bus.job_radius = '0;
      bus.job_mode = '0;
      bus.job_tag = '0;
      bus.set_busy = 1'b0;
      bus.set_candidate = '0;
      bus.res_ready = 1'b1;
      exp_done = 0;

      step();
      step();
      check("rst_job_ready", bus.job_ready, 1);
      check("rst_set_en", bus.set_en, 0);
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_fifo_level", fifo_level, 0);
      check("rst_jobs_done", jobs_done, 0);
      check("rst_set_fields", {bus.set_central, bus.set_radius, bus.set_mode}, 0);
      check("rst_res_fields", {bus.res_candidate, bus.res_tag, bus.res_err}, 0);
      rst = 1'b0;
      step();

      // Table: one job at a time with varied engine behaviour.
      for (int i = 0; i < 6; i++) begin
         eng_lat  = vecs[i].lat;
         eng_mute = vecs[i].mute;
         bus.set_candidate = vecs[i].cand;
         base_en  = set_en_count;
         expect_res(vecs[i].exp_cand, vecs[i].tag, vecs[i].exp_err,
                    vecs[i].exp_err ? TO + 2 : vecs[i].lat + 2);
         offer(vecs[i].central, vecs[i].radius, vecs[i].mode, vecs[i].tag);
         check("vec_job_ready", bus.job_ready, 1);
         step();
         bus.job_valid = 1'b0;
         exp_done++;
         wait_done(exp_done, 300, "vec_jobs_done");
         check("vec_one_set_en", 64'(set_en_count - base_en), 1);
         check("vec_set_fields_held", {bus.set_central, bus.set_radius, bus.set_mode},
               {vecs[i].central, vecs[i].radius, vecs[i].mode});
      end

      // Fill the FIFO with the engine busy, then release it.
      eng_lat = 2;
      eng_mute = 1'b0;
      bus.set_candidate = 8'h3C;
      bus.set_busy = 1'b1;
      base_en = set_en_count;
      max_lvl = 0;
      for (int k = 0; k < 5; k++) begin
         offer(24'h100000 + 24'(k), 12'h010 * 12'(k), 2'(k), 4'(8 + k));
         expect_res(8'h3C, 4'(8 + k), 1'b0, 4);
         check("fill_job_ready", bus.job_ready, (k < 4) ? 1 : 0);
         step();
         if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      end
      check("fill_level_full", fifo_level, 4);
      check("fill_job_ready_low", bus.job_ready, 0);
      for (int k = 0; k < 3; k++) step();
      check("fill_no_set_en_while_busy", 64'(set_en_count - base_en), 0);
      bus.set_busy = 1'b0;
      n = 0;
      do begin
         step();
         n++;
         if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      end while (!bus.job_ready && n < 10);
      check("fill_ready_after_pop", bus.job_ready, 1);
      check("fill_pop_issues", bus.set_en, 1);
      check("fill_level_after_pop", fifo_level, 3);
      step();
      bus.job_valid = 1'b0;
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      check("fill_fifth_accepted", fifo_level, 4);
      check("fill_max_level", 64'(max_lvl), 4);
      exp_done += 5;
      wait_done(exp_done, 400, "fill_jobs_done");

      // Push and pop on the same edge keep the level.
      bus.set_busy = 1'b1;
      bus.set_candidate = 8'h21;
      for (int k = 1; k <= 2; k++) begin
         offer(24'h0000f0 + 24'(k), 12'h00f, 2'd1, 4'(k));
         expect_res(8'h21, 4'(k), 1'b0, 4);
         step();
      end
      bus.job_valid = 1'b0;
      check("pp_level_before", fifo_level, 2);
      bus.set_busy = 1'b0;
      offer(24'h0000f3, 12'h00f, 2'd1, 4'd3);
      expect_res(8'h21, 4'd3, 1'b0, 4);
      step();
      bus.job_valid = 1'b0;
      check("pp_level_same", fifo_level, 2);
      check("pp_issue", bus.set_en, 1);
      exp_done += 3;
      wait_done(exp_done, 200, "pp_jobs_done");

      // Result held while res_ready is low; queued job must not start.
      bus.res_ready = 1'b0;
      eng_lat = 4;
      bus.set_candidate = 8'h99;
      expect_res(8'h99, 4'd6, 1'b0, 6);
      offer(24'h505050, 12'h505, 2'd2, 4'd6);
      step();
      offer(24'h606060, 12'h606, 2'd3, 4'd2);
      step();
      bus.job_valid = 1'b0;
      n = 0;
      while (!bus.res_valid && n < 50) begin
         step();
         n++;
      end
      check("hold_res_valid", bus.res_valid, 1);
      bus.set_candidate = 8'h55;
      base_en = set_en_count;
      for (int k = 0; k < 20; k++) begin
         step();
         check("hold_res_stable", {bus.res_valid, bus.res_candidate, bus.res_tag, bus.res_err},
               {1'b1, 8'h99, 4'd6, 1'b0});
      end
      check("hold_no_set_en", 64'(set_en_count - base_en), 0);
      check("hold_level", fifo_level, 1);
      expect_res(8'h55, 4'd2, 1'b0, 6);
      bus.res_ready = 1'b1;
      exp_done += 2;
      wait_done(exp_done, 200, "hold_jobs_done");

      // Stray set_valid while idle is ignored.
      base_en = set_en_count;
      bus.set_candidate = 8'hAB;
      inject_sv = 1'b1;
      step();
      inject_sv = 1'b0;
      for (int k = 0; k < 4; k++) step();
      check("idle_sv_no_result", bus.res_valid, 0);
      check("idle_sv_jobs_done", jobs_done, 16'(exp_done));
      check("idle_sv_no_set_en", 64'(set_en_count - base_en), 0);
      eng_lat = 5;
      bus.set_candidate = 8'h42;
      expect_res(8'h42, 4'd1, 1'b0, 7);
      offer(24'h777777, 12'h777, 2'd0, 4'd1);
      step();
      bus.job_valid = 1'b0;
      exp_done++;
      wait_done(exp_done, 100, "idle_sv_next_job");

      // Reset ten cycles into WAIT with two jobs queued.
      eng_mute = 1'b1;
      offer(24'h333333, 12'h333, 2'd1, 4'd4);
      step();
      bus.job_valid = 1'b0;
      n = 0;
      while (!bus.set_en && n < 20) begin
         step();
         n++;
      end
      check("rstmid_issue", bus.set_en, 1);
      offer(24'h111111, 12'h111, 2'd2, 4'd11);
      step();
      offer(24'h222222, 12'h222, 2'd3, 4'd12);
      step();
      bus.job_valid = 1'b0;
      for (int k = 0; k < 8; k++) step();
      check("rstmid_level_before", fifo_level, 2);
      rst = 1'b1;
      #1;
      sb.delete();
      check("rstmid_fifo_level", fifo_level, 0);
      check("rstmid_job_ready", bus.job_ready, 1);
      check("rstmid_set_en", bus.set_en, 0);
      check("rstmid_res_valid", bus.res_valid, 0);
      check("rstmid_jobs_done", jobs_done, 0);
      check("rstmid_set_fields", {bus.set_central, bus.set_radius, bus.set_mode}, 0);
      check("rstmid_res_fields", {bus.res_candidate, bus.res_tag, bus.res_err}, 0);
      step();
      step();
      rst = 1'b0;
      base_en = set_en_count;
      rv_cnt = 0;
      for (int k = 0; k < 150; k++) begin
         step();
         if (bus.res_valid) rv_cnt++;
      end
      check("rstmid_no_result_after", 64'(rv_cnt), 0);
      check("rstmid_no_issue_after", 64'(set_en_count - base_en), 0);
      check("rstmid_jobs_done_after", jobs_done, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/set_job_scheduler.md
SET_JOB_SCHEDULER -- requirements
Module: set_job_scheduler

Interface
REQ-001 Parameters SHALL be: FIFO_DEPTH, default 4, job FIFO entries (power of 2); TIMEOUT, default 96, max cycles from set_en to set_valid.
REQ-002 Ports SHALL be, clock and reset first: clk in 1 clock; rst in 1 reset, asynchronous, active-high.
REQ-003 job_valid in 1 job offered; job_ready out 1 FIFO not full; job_central in 24 three 4-bit (x,y) centres; job_radius in 12 three 4-bit radii; job_mode in 2 set mode; job_tag in 4 job identifier.
REQ-004 set_en out 1 one-cycle start to SET engine; set_central out 24; set_radius out 12; set_mode out 2; set_busy in 1; set_valid in 1; set_candidate in 8.
REQ-005 res_valid out 1 result held; res_ready in 1 result consumed; res_candidate out 8; res_tag out 4; res_err out 1 timeout flag.
REQ-006 jobs_done out 16 completed-job count; fifo_level out 3 current occupancy.

Function
REQ-007 Job accepted SHALL occur on a clk edge with job_valid=1 and job_ready=1; {central,radius,mode,tag} written to FIFO tail.
REQ-008 job_ready SHALL equal (fifo_level != FIFO_DEPTH); simultaneous push and pop when full SHALL NOT be accepted (ready is already low).
REQ-009 FSM states SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-010 IDLE->ISSUE when FIFO non-empty, res_valid=0 and set_busy=0; FIFO head popped on this transition.
REQ-011 ISSUE SHALL last exactly one cycle with set_en=1 and set_central/set_radius/set_mode driven from the popped entry; ISSUE->WAIT unconditionally.
REQ-012 set_central/set_radius/set_mode SHALL hold their value from ISSUE until the next ISSUE.
REQ-013 WAIT SHALL increment a timeout counter from 0 each cycle; on set_valid=1, capture set_candidate into res_candidate, res_err=0, go DONE.
REQ-014 If counter reaches TIMEOUT-1 without set_valid: res_candidate=0, res_err=1, go DONE; set_valid in the same cycle SHALL take priority over timeout.
REQ-015 DONE SHALL last one cycle: res_valid<=1, res_tag<=tag of issued job, jobs_done+1 (wraps at 65535->0), then IDLE.
REQ-016 res_valid SHALL stay 1 with stable res_* until a clk edge with res_ready=1; clears on that edge.
REQ-017 set_valid outside WAIT SHALL be ignored.
REQ-018 set_en SHALL never assert while set_busy=1 or in two consecutive cycles.
REQ-019 Nominal latency: set_en to res_valid = SET engine latency + 2 cycles; one job in flight at a time.
REQ-020 fifo_level SHALL reflect push and pop in the same cycle (net unchanged when both occur, non-full).

Reset
REQ-021 rst SHALL asynchronously force: FSM IDLE, FIFO empty, fifo_level=0, job_ready=1, set_en=0, set_central=0, set_radius=0, set_mode=0, res_valid=0, res_candidate=0, res_tag=0, res_err=0, jobs_done=0, timeout counter=0.
REQ-022 rst mid-job SHALL discard the in-flight job and all queued jobs; no result emitted.

Structure
REQ-023 Shared package set_pkg SHALL hold: width constants (CENTRAL_W=24, RADIUS_W=12, MODE_W=2, TAG_W=4, CAND_W=8), FSM state encoding, default TIMEOUT and FIFO_DEPTH.
REQ-024 FIFO SHALL be a separate sub-module set_job_fifo (synchronous, registered head, 42-bit entries).

Verification
REQ-025 Single job central=0x444444, radius=0x333, mode=0, tag=5, engine returns 29 -> exactly one set_en pulse, res_candidate=29, res_tag=5, res_err=0, jobs_done=1.
REQ-026 Push 5 jobs back-to-back with FIFO_DEPTH=4, no pops -> job_ready=0 after 4th, 5th stalled until first pop, fifo_level max 4.
REQ-027 Hold res_ready=0 for 20 cycles after result -> res_* stable, no new set_en while res_valid=1.
REQ-028 Engine never asserts set_valid -> after 96 cycles in WAIT res_valid=1, res_err=1, res_candidate=0, next job issued.
REQ-029 Assert rst 10 cycles into WAIT with 2 queued jobs -> all outputs at reset values, fifo_level=0, no res_valid afterwards.
REQ-030 set_valid pulse while IDLE and set_valid coincident with timeout cycle -> first ignored; second yields res_err=0 with captured candidate.
